// File: rtl/mig_tt_engine_if.sv
// Configuration and result bus of the MIG truth-table engine.
// The self_dual flag exists only when MIG_SELFDUAL_EN is defined.
interface mig_tt_engine_if #(
    parameter int unsigned N = 7,
    parameter int unsigned G = 6
);
    localparam int unsigned SELW = $clog2(1 + N + G);
    localparam int unsigned DW   = 3 * (SELW + 1);
    localparam int unsigned AW   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned TT   = 1 << N;

    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_out_inv;
    logic          start;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [TT-1:0] tt;
`ifdef MIG_SELFDUAL_EN
    logic          self_dual;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_out_inv, start, out_ready,
        input  busy, out_valid, tt
`ifdef MIG_SELFDUAL_EN
        , input self_dual
`endif
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_out_inv, start, out_ready,
        output busy, out_valid, tt
`ifdef MIG_SELFDUAL_EN
        , output self_dual
`endif
    );
endinterface

// File: rtl/mig_tt_engine.sv
// Programmable MIG evaluator: sweeps all 2^N minterms and returns the truth table.
// Optional self-duality flag enabled by MIG_SELFDUAL_EN.
module mig_tt_engine #(
    parameter int unsigned N = 7,
    parameter int unsigned G = 6
) (
    input  logic            clk,
    input  logic            rst,
    mig_tt_engine_if.slave  bus
);
    localparam int unsigned SELW = $clog2(1 + N + G);
    localparam int unsigned OPW  = SELW + 1;
    localparam int unsigned DW   = 3 * OPW;
    localparam int unsigned TT   = 1 << N;
    localparam int unsigned SIGS = 1 << SELW;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t          state, state_d;
    logic [DW-1:0]   desc [G];
    logic [N-1:0]    m;
    logic [TT-1:0]   tt_q;
    logic            out_inv_q;
    logic            w0_q;
    logic            busy_q;
    logic            valid_q;

    logic            start_c;
    logic            last_c;
    logic [N-1:0]    m_eval;
    logic [SIGS-1:0] sig;
    logic [SELW-1:0] sel;
    logic [2:0]      opv;
    logic            w_last;
    logic            bit_c;

    // Next-state logic.
    always_comb begin
        state_d = state;
        start_c = 1'b0;
        last_c  = (m == '1);
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    start_c = 1'b1;
                end
            end
            SWEEP: begin
                if (last_c) state_d = DONE;
            end
            DONE: begin
                if (valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Network evaluation; selects at or beyond the gate's own index read as 0.
    always_comb begin
        m_eval = (state == IDLE) ? '0 : m;
        sig    = '0;
        sel    = '0;
        opv    = '0;
        sig[N:1] = m_eval;
        for (int g = 0; g < int'(G); g++) begin
            for (int k = 0; k < 3; k++) begin
                sel    = desc[g][k*OPW +: SELW];
                opv[k] = ((32'(sel) < N + 1 + 32'(g)) ? sig[sel] : 1'b0) ^ desc[g][k*OPW + SELW];
            end
            sig[N + 1 + g] = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
        end
        w_last = sig[N + G];
    end

    // Minterm 0 uses the network as it stood in the start cycle.
    assign bit_c = ((m == '0) ? w0_q : w_last) ^ out_inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            m         <= '0;
            tt_q      <= '0;
            out_inv_q <= 1'b0;
            w0_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            busy_q  <= (state_d != IDLE);
            valid_q <= (state == DONE) && (state_d == DONE);
            if (start_c) begin
                m         <= '0;
                tt_q      <= '0;
                out_inv_q <= bus.cfg_out_inv;
                w0_q      <= w_last;
            end else if (state == SWEEP) begin
                tt_q[m] <= bit_c;
                if (!last_c) m <= m + 1'b1;
            end
        end
    end

    // Descriptor file: writable only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < int'(G); g++) desc[g] <= '0;
        end else if ((state == IDLE) && bus.cfg_we && (32'(bus.cfg_addr) < G)) begin
            desc[bus.cfg_addr] <= bus.cfg_data;
        end
    end

`ifdef MIG_SELFDUAL_EN
    logic [TT-1:0] tt_fin;
    logic          sd_c;
    logic          self_dual_q;

    // Self-duality over the completed table, including the minterm written this cycle.
    always_comb begin
        tt_fin    = tt_q;
        tt_fin[m] = bit_c;
        sd_c      = 1'b1;
        for (int i = 0; i < int'(TT / 2); i++) begin
            sd_c = sd_c & (tt_fin[i] ^ tt_fin[TT - 1 - i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                     self_dual_q <= 1'b0;
        else if (start_c)                            self_dual_q <= 1'b0;
        else if ((state == SWEEP) && (state_d == DONE)) self_dual_q <= sd_c;
    end

    assign bus.self_dual = self_dual_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.tt        = tt_q;
endmodule

// File: tb/tb_mig_tt_engine.sv
// Directed self-checking bench for mig_tt_engine (N=7, G=6).
module tb_mig_tt_engine;
    localparam int unsigned N    = 7;
    localparam int unsigned G    = 6;
    localparam int unsigned SELW = 4;
    localparam int unsigned OPW  = SELW + 1;
    localparam int unsigned DW   = 3 * OPW;
    localparam int unsigned AW   = 3;
    localparam int unsigned TT   = 128;

    localparam logic [TT-1:0] TT_ZERO = '0;
    localparam logic [TT-1:0] TT_X0   = {4{32'hAAAA_AAAA}};
    localparam logic [TT-1:0] TT_NX0  = {4{32'h5555_5555}};
    localparam logic [TT-1:0] TT_FULL = 128'hfeeaeaa8fee8e880fee8e880eaa8a880;
    localparam logic [TT-1:0] TT_AND  = {16{8'hC0}};
    localparam logic [TT-1:0] TT_PART = {88'h0, 40'hC0C0C0C0C0};
    localparam logic [TT-1:0] TT_ONE0 = {{127{1'b1}}, 1'b0};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mig_tt_engine_if #(.N(N), .G(G)) bus ();

    mig_tt_engine #(.N(N), .G(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chktt(input string tag, input logic [TT-1:0] obs, input logic [TT-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [OPW-1:0] op(input logic c, input int unsigned s);
        return {c, SELW'(s)};
    endfunction

    task automatic wr(input int unsigned a, input logic [DW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    // Start a sweep and check the 129-cycle latency to out_valid.
    task automatic run_sweep(input logic inv);
        bus.cfg_out_inv = inv;
        bus.start       = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        chk1("busy_after_start", bus.busy, 1'b1);
        repeat (TT) tick();
        chk1("valid_low_at_128", bus.out_valid, 1'b0);
        chk1("busy_at_128", bus.busy, 1'b1);
        tick();
        chk1("valid_high_at_129", bus.out_valid, 1'b1);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1("ack_valid_low", bus.out_valid, 1'b0);
        chk1("ack_busy_low", bus.busy, 1'b0);
    endtask

    task automatic program_full();
        wr(0, {op(0, 4), op(0, 3), op(0, 2)});
        wr(1, {op(0, 4), op(0, 3), op(0, 1)});
        wr(2, {op(0, 8), op(0, 7), op(0, 6)});
        wr(3, {op(0, 9), op(0, 2), op(0, 1)});
        wr(4, {op(0, 11), op(0, 10), op(0, 5)});
        wr(5, {op(0, 12), op(0, 8), op(0, 1)});
    endtask

    initial begin
        rst             = 1'b1;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
        bus.cfg_out_inv = 1'b0;
        bus.start       = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_valid", bus.out_valid, 1'b0);
        chktt("reset_tt", bus.tt, TT_ZERO);

        // Unconfigured network evaluates to constant 0.
        run_sweep(1'b0);
        chktt("empty_tt", bus.tt, TT_ZERO);
`ifdef MIG_SELFDUAL_EN
        chk1("empty_sd", bus.self_dual, 1'b0);
`endif
        ack();

        // Gate5 = MAJ(x0, 0, 1) = x0, plain and complemented.
        wr(5, {op(1, 0), op(0, 0), op(0, 1)});
        run_sweep(1'b0);
        chktt("ident_tt", bus.tt, TT_X0);
`ifdef MIG_SELFDUAL_EN
        chk1("ident_sd", bus.self_dual, 1'b1);
`endif
        ack();
        run_sweep(1'b1);
        chktt("ident_inv_tt", bus.tt, TT_NX0);
`ifdef MIG_SELFDUAL_EN
        chk1("ident_inv_sd", bus.self_dual, 1'b1);
`endif
        ack();

        // Full six-gate network, then back-pressure with ignored start/cfg_we.
        program_full();
        run_sweep(1'b0);
        chktt("full_tt", bus.tt, TT_FULL);
`ifdef MIG_SELFDUAL_EN
        chk1("full_sd", bus.self_dual, 1'b1);
`endif
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.start = 1'b1;
            if (i == 5) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = AW'(5);
                bus.cfg_data = '0;
            end
            tick();
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            chktt("hold_tt", bus.tt, TT_FULL);
            chk1("hold_valid", bus.out_valid, 1'b1);
        end
        ack();
        tick();
        chk1("start_not_queued", bus.busy, 1'b0);
        run_sweep(1'b0);
        chktt("desc_unchanged_tt", bus.tt, TT_FULL);
        ack();

        // Forward reference: gate0 s0 points at w3 and reads 0; output = w0.
        wr(0, {op(0, 3), op(0, 2), op(0, 11)});
        wr(5, {op(0, 8), op(0, 8), op(0, 0)});
        run_sweep(1'b0);
        chktt("fwdref_tt", bus.tt, TT_AND);
        ack();

        // Reset at minterm 40 discards the partial result and descriptors.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (40) tick();
        chktt("partial_tt", bus.tt, TT_PART);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_valid", bus.out_valid, 1'b0);
        chktt("midrst_tt", bus.tt, TT_ZERO);
        program_full();
        run_sweep(1'b0);
        chktt("after_rst_tt", bus.tt, TT_FULL);
`ifdef MIG_SELFDUAL_EN
        chk1("after_rst_sd", bus.self_dual, 1'b1);
`endif
        ack();

        // Write and start together: minterm 0 sees the old gate5, the rest the new constant 1.
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(5);
        bus.cfg_data = {op(0, 0), op(1, 0), op(1, 0)};
        run_sweep(1'b0);
        chktt("same_cycle_tt", bus.tt, TT_ONE0);
`ifdef MIG_SELFDUAL_EN
        chk1("same_cycle_sd", bus.self_dual, 1'b0);
`endif
        ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
